sparse_dot_array: RTL

- Parametrised successor to the fixed four-BRAM / two-comparator top level. NUM_LANES independent lanes.
- Each lane buffers two sparse vectors, A and B, as (index, value) pairs sorted by ascending index.
- On start, each lane runs a merge-intersection and accumulates the signed dot product over matching indices.
- Sits between the row loader and the result collector of the sparse matrix multiplier.

---
 rtl/sparse_pkg.sv | 32 +++
 rtl/sparse_dot_array_if.sv | 22 ++
 rtl/sparse_dot_lane.sv | 134 +++++++++++++
 rtl/sparse_dot_array.sv | 100 ++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sparse_pkg
// Brief    : Shared types, defaults and helpers for the sparse dot-product array.
// Revision : 1.0
// ============================================================================
package sparse_pkg;

    localparam int DEF_NUM_LANES = 2;
    localparam int DEF_IDX_W     = 16;
    localparam int DEF_VAL_W     = 16;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_ACC_W     = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic        [DEF_IDX_W-1:0] idx;
        logic signed [DEF_VAL_W-1:0] val;
    } elem_t;

    // A single lane still needs a one-bit select field.
    function automatic int lane_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_dot_array_if.sv
`default_nettype none
// ============================================================================
// Module   : sparse_dot_array_if
// Brief    : Element write channel from the row loader into the lane buffers.
// Revision : 1.0
// ============================================================================
interface sparse_dot_array_if #(
    parameter int LANE_W = 1,
    parameter int IDX_W  = 16,
    parameter int VAL_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic       [LANE_W-1:0] in_lane;
    logic                    in_side;
    logic        [IDX_W-1:0] in_idx;
    logic signed [VAL_W-1:0] in_val;

    modport master (output in_valid, in_lane, in_side, in_idx, in_val, input in_ready);
    modport slave  (input in_valid, in_lane, in_side, in_idx, in_val, output in_ready);
endinterface
`default_nettype wire

// File: rtl/sparse_dot_lane.sv
`default_nettype none
// ============================================================================
// Module   : sparse_dot_lane
// Brief    : One lane: A/B element buffers plus merge-intersection MAC.
// Revision : 1.0
// ============================================================================
module sparse_dot_lane
    import sparse_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int VAL_W = DEF_VAL_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ACC_W = DEF_ACC_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic                    wr_en,
    input  wire logic                    wr_side,
    input  wire logic [IDX_W+VAL_W-1:0]  wr_elem,
    input  wire logic                    clear_res,
    input  wire logic                    clear_buf,
    input  wire logic                    step,
    output logic                         finished,
    output logic signed [ACC_W-1:0]      result,
    output logic        [CNT_W-1:0]      match_count,
    output logic                         overflow,
    output logic                         order_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    typedef struct packed {
        logic        [IDX_W-1:0] idx;
        logic signed [VAL_W-1:0] val;
    } lane_elem_t;

    lane_elem_t r_mem_a [DEPTH];
    lane_elem_t r_mem_b [DEPTH];

    logic [CNT_W-1:0] r_cnt_a, r_cnt_b, r_ptr_a, r_ptr_b, r_match;
    logic [IDX_W-1:0] r_last_a, r_last_b;
    logic signed [ACC_W-1:0] r_acc;
    logic r_ovf, r_oerr;

    lane_elem_t w_wr, w_a, w_b;
    logic w_full, w_has_prev, w_out_of_order;
    logic signed [VAL_W-1:0]   w_a_val, w_b_val;
    logic signed [2*VAL_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;

    assign w_wr           = wr_elem;
    assign w_full         = wr_side ? (r_cnt_b == c_depth) : (r_cnt_a == c_depth);
    assign w_has_prev     = wr_side ? (r_cnt_b != '0) : (r_cnt_a != '0);
    // Last accepted index is kept in a register so the buffers need only one read port.
    assign w_out_of_order = w_has_prev && (w_wr.idx <= (wr_side ? r_last_b : r_last_a));

    assign w_a        = r_mem_a[r_ptr_a[AW-1:0]];
    assign w_b        = r_mem_b[r_ptr_b[AW-1:0]];
    assign w_a_val    = w_a.val;
    assign w_b_val    = w_b.val;
    assign w_prod     = w_a_val * w_b_val;
    assign w_prod_ext = {{(ACC_W-2*VAL_W){w_prod[2*VAL_W-1]}}, w_prod};
    assign finished   = (r_ptr_a == r_cnt_a) || (r_ptr_b == r_cnt_b);

    always_ff @(posedge clk) begin
        if (wr_en && !w_full) begin
            if (wr_side) r_mem_b[r_cnt_b[AW-1:0]] <= w_wr;
            else         r_mem_a[r_cnt_a[AW-1:0]] <= w_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_last_a <= '0;
            r_last_b <= '0;
            r_ovf    <= 1'b0;
            r_oerr   <= 1'b0;
            r_ptr_a  <= '0;
            r_ptr_b  <= '0;
            r_match  <= '0;
            r_acc    <= '0;
        end else begin
            if (clear_buf) begin
                r_cnt_a  <= '0;
                r_cnt_b  <= '0;
                r_last_a <= '0;
                r_last_b <= '0;
                r_ovf    <= 1'b0;
                r_oerr   <= 1'b0;
            end else if (wr_en) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    if (w_out_of_order) r_oerr <= 1'b1;
                    if (wr_side) begin
                        r_cnt_b  <= r_cnt_b + 1'b1;
                        r_last_b <= w_wr.idx;
                    end else begin
                        r_cnt_a  <= r_cnt_a + 1'b1;
                        r_last_a <= w_wr.idx;
                    end
                end
            end

            if (clear_res) begin
                r_ptr_a <= '0;
                r_ptr_b <= '0;
                r_match <= '0;
                r_acc   <= '0;
            end else if (step && !finished) begin
                if (w_a.idx == w_b.idx) begin
                    r_acc   <= r_acc + w_prod_ext;
                    r_ptr_a <= r_ptr_a + 1'b1;
                    r_ptr_b <= r_ptr_b + 1'b1;
                    r_match <= r_match + 1'b1;
                end else if (w_a.idx < w_b.idx) begin
                    r_ptr_a <= r_ptr_a + 1'b1;
                end else begin
                    r_ptr_b <= r_ptr_b + 1'b1;
                end
            end
        end
    end

    assign result      = r_acc;
    assign match_count = r_match;
    assign overflow    = r_ovf;
    assign order_err   = r_oerr;

endmodule
`default_nettype wire

// File: rtl/sparse_dot_array.sv
`default_nettype none
// ============================================================================
// Module   : sparse_dot_array
// Brief    : NUM_LANES sparse dot-product lanes behind one load/run/done FSM.
// Revision : 1.0
// ============================================================================
module sparse_dot_array
    import sparse_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int VAL_W     = DEF_VAL_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ACC_W     = DEF_ACC_W,
    localparam int LANE_W   = lane_width(NUM_LANES),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    sparse_dot_array_if.slave               wr,
    input  wire logic                       start,
    output logic                            busy,
    output logic                            done,
    output logic [NUM_LANES*ACC_W-1:0]      result,
    output logic [NUM_LANES*CNT_W-1:0]      match_count,
    output logic [NUM_LANES-1:0]            overflow,
    output logic [NUM_LANES-1:0]            order_err
);
    state_t r_state;
    logic   r_ready, r_busy, r_done;

    logic [NUM_LANES-1:0] w_fin;
    logic w_wr_acc, w_step, w_clear_res, w_clear_buf;

    assign w_wr_acc    = wr.in_valid && r_ready;
    assign w_step      = (r_state == RUN);
    assign w_clear_res = (r_state == IDLE) && start;
    assign w_clear_buf = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
                RUN: if (&w_fin) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr.in_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;

    // Lane selects beyond NUM_LANES match no instance, so such writes vanish.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic w_wr_en;
        assign w_wr_en = w_wr_acc && (wr.in_lane == LANE_W'(i));

        sparse_dot_lane #(
            .IDX_W (IDX_W),
            .VAL_W (VAL_W),
            .DEPTH (DEPTH),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (w_wr_en),
            .wr_side     (wr.in_side),
            .wr_elem     ({wr.in_idx, wr.in_val}),
            .clear_res   (w_clear_res),
            .clear_buf   (w_clear_buf),
            .step        (w_step),
            .finished    (w_fin[i]),
            .result      (result[i*ACC_W +: ACC_W]),
            .match_count (match_count[i*CNT_W +: CNT_W]),
            .overflow    (overflow[i]),
            .order_err   (order_err[i])
        );
    end

endmodule
`default_nettype wire
